// File: rtl/hash_query.sv
// Three-table hash lookup: hashes a 32-bit key into three table addresses,
// collects one nibble per table and reports the result, abandoning tables that stay silent.
module hash_query #(
  parameter int TIMEOUT = 15
) (
  input  logic        Sys_clk,
  input  logic        Rst,
  input  logic [31:0] Key_in,
  input  logic        Key_valid,
  output logic        Key_ready,
  output logic        Hash_valid,
  output logic [11:0] Hash_add1,
  output logic [10:0] Hash_add2,
  output logic [9:0]  Hash_add3,
  input  logic [3:0]  Hash_rdata1,
  input  logic [3:0]  Hash_rdata2,
  input  logic [3:0]  Hash_rdata3,
  input  logic        Hash_rdata1_wr,
  input  logic        Hash_rdata2_wr,
  input  logic        Hash_rdata3_wr,
  output logic [11:0] Result_data,
  output logic        Result_valid,
  output logic        Result_timeout
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [2:0]  r_flags;
  logic [2:0]  w_strobes;
  logic [2:0]  w_flags_next;
  logic [11:0] r_data;
  logic [11:0] w_data_next;
  logic [7:0]  r_cnt;
  logic [7:0]  w_cnt_inc;
  logic        r_to;
  logic [11:0] r_add1;
  logic [10:0] r_add2;
  logic [9:0]  r_add3;
  logic [11:0] r_result_data;
  logic        r_result_valid;
  logic        r_result_timeout;
  logic [11:0] w_add1;
  logic [10:0] w_add2;
  logic [9:0]  w_add3;
  logic        w_complete;

  assign w_add1 = Key_in[11:0] ^ Key_in[23:12] ^ {4'h0, Key_in[31:24]};
  assign w_add2 = Key_in[10:0] ^ Key_in[21:11] ^ {1'b0, Key_in[31:22]};
  assign w_add3 = Key_in[9:0]  ^ Key_in[19:10] ^ Key_in[29:20];

  assign w_strobes  = {Hash_rdata3_wr, Hash_rdata2_wr, Hash_rdata1_wr};
  assign w_cnt_inc  = r_cnt + 8'd1;
  // A strobe arriving this cycle already counts towards completion.
  assign w_complete = &w_flags_next;

  always_comb begin
    w_flags_next = r_flags | w_strobes;
    w_data_next  = r_data;
    if (Hash_rdata1_wr) w_data_next[3:0]  = Hash_rdata1;
    if (Hash_rdata2_wr) w_data_next[7:4]  = Hash_rdata2;
    if (Hash_rdata3_wr) w_data_next[11:8] = Hash_rdata3;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (Key_valid) w_state_next = ISSUE;
      ISSUE:   w_state_next = WAIT;
      WAIT:    if (w_complete || (w_cnt_inc == 8'(TIMEOUT))) w_state_next = DONE;
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge Sys_clk) begin
    if (Rst) begin
      r_state          <= IDLE;
      r_flags          <= 3'b000;
      r_cnt            <= 8'd0;
      r_to             <= 1'b0;
      r_add1           <= 12'd0;
      r_add2           <= 11'd0;
      r_add3           <= 10'd0;
      r_result_valid   <= 1'b0;
      r_result_data    <= 12'd0;
      r_result_timeout <= 1'b0;
    end else begin
      r_state        <= w_state_next;
      r_result_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (Key_valid) begin
            r_add1 <= w_add1;
            r_add2 <= w_add2;
            r_add3 <= w_add3;
          end
        end
        ISSUE: begin
          // Clearing the data makes silent tables report zero.
          r_flags <= 3'b000;
          r_cnt   <= 8'd0;
          r_data  <= 12'd0;
        end
        WAIT: begin
          r_flags <= w_flags_next;
          r_data  <= w_data_next;
          r_to    <= ~w_complete;
          if (!w_complete) r_cnt <= w_cnt_inc;
        end
        DONE: begin
          r_result_valid   <= 1'b1;
          r_result_data    <= r_data;
          r_result_timeout <= r_to;
        end
        default: ;
      endcase
    end
  end

  assign Key_ready      = (r_state == IDLE);
  assign Hash_valid     = (r_state == ISSUE);
  assign Hash_add1      = r_add1;
  assign Hash_add2      = r_add2;
  assign Hash_add3      = r_add3;
  assign Result_data    = r_result_data;
  assign Result_valid   = r_result_valid;
  assign Result_timeout = r_result_timeout;

endmodule

// File: tb/tb_hash_query.sv
// Directed-vector bench for hash_query (default TIMEOUT = 15).
module tb_hash_query;

  logic        Sys_clk = 1'b0;
  logic        Rst;
  logic [31:0] Key_in;
  logic        Key_valid;
  logic        Key_ready;
  logic        Hash_valid;
  logic [11:0] Hash_add1;
  logic [10:0] Hash_add2;
  logic [9:0]  Hash_add3;
  logic [3:0]  Hash_rdata1, Hash_rdata2, Hash_rdata3;
  logic        Hash_rdata1_wr, Hash_rdata2_wr, Hash_rdata3_wr;
  logic [11:0] Result_data;
  logic        Result_valid;
  logic        Result_timeout;

  int checks = 0;
  int errors = 0;

  hash_query dut (
    .Sys_clk(Sys_clk), .Rst(Rst), .Key_in(Key_in), .Key_valid(Key_valid),
    .Key_ready(Key_ready), .Hash_valid(Hash_valid),
    .Hash_add1(Hash_add1), .Hash_add2(Hash_add2), .Hash_add3(Hash_add3),
    .Hash_rdata1(Hash_rdata1), .Hash_rdata2(Hash_rdata2), .Hash_rdata3(Hash_rdata3),
    .Hash_rdata1_wr(Hash_rdata1_wr), .Hash_rdata2_wr(Hash_rdata2_wr),
    .Hash_rdata3_wr(Hash_rdata3_wr),
    .Result_data(Result_data), .Result_valid(Result_valid), .Result_timeout(Result_timeout)
  );

  always #5 Sys_clk = ~Sys_clk;

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge Sys_clk);
    #1;
  endtask

  task automatic strb(input logic [2:0] wr, input logic [3:0] d1, input logic [3:0] d2,
                      input logic [3:0] d3);
    Hash_rdata1_wr = wr[0];
    Hash_rdata2_wr = wr[1];
    Hash_rdata3_wr = wr[2];
    Hash_rdata1 = d1;
    Hash_rdata2 = d2;
    Hash_rdata3 = d3;
  endtask

  // Presents a key for one cycle; returns in the cycle after acceptance.
  task automatic start(input logic [31:0] k);
    Key_in = k;
    Key_valid = 1'b1;
    tick();
    Key_valid = 1'b0;
  endtask

  task automatic wait_result(input int max_cyc, output int lat, output logic got);
    got = 1'b0;
    lat = 0;
    while (!got && lat < max_cyc) begin
      tick();
      lat++;
      if (Result_valid === 1'b1) got = 1'b1;
    end
  endtask

  task automatic test_reset();
    Rst = 1'b1;
    Key_valid = 1'b0;
    Key_in = 32'h0;
    strb(3'b000, 4'h0, 4'h0, 4'h0);
    tick();
    tick();
    checks++; if (Key_ready !== 1'b1) begin errors++; $display("FAIL rst_key_ready got %b exp 1", Key_ready); end
    checks++; if (Hash_valid !== 1'b0) begin errors++; $display("FAIL rst_hash_valid got %b exp 0", Hash_valid); end
    checks++; if ({Hash_add1, Hash_add2, Hash_add3} !== 33'd0) begin errors++; $display("FAIL rst_addr got %h/%h/%h exp 0", Hash_add1, Hash_add2, Hash_add3); end
    checks++; if (Result_valid !== 1'b0) begin errors++; $display("FAIL rst_result_valid got %b exp 0", Result_valid); end
    checks++; if (Result_data !== 12'h000 || Result_timeout !== 1'b0) begin errors++; $display("FAIL rst_result got %h/%b exp 000/0", Result_data, Result_timeout); end
    Rst = 1'b0;
    tick();
  endtask

  task automatic test_zero_key();
    start(32'h0000_0000);
    checks++; if (Hash_valid !== 1'b1) begin errors++; $display("FAIL zero_hash_valid got %b exp 1", Hash_valid); end
    checks++; if (Key_ready !== 1'b0) begin errors++; $display("FAIL zero_key_ready got %b exp 0", Key_ready); end
    checks++; if ({Hash_add1, Hash_add2, Hash_add3} !== 33'd0) begin errors++; $display("FAIL zero_addr got %h/%h/%h exp 0", Hash_add1, Hash_add2, Hash_add3); end
    tick();
    strb(3'b111, 4'h1, 4'h2, 4'h3);
    checks++; if (Hash_valid !== 1'b0) begin errors++; $display("FAIL zero_hash_valid_pulse got %b exp 0", Hash_valid); end
    tick();
    strb(3'b000, 4'h0, 4'h0, 4'h0);
    checks++; if (Result_valid !== 1'b0) begin errors++; $display("FAIL zero_early_result got %b exp 0", Result_valid); end
    tick();
    checks++; if (Result_valid !== 1'b1) begin errors++; $display("FAIL zero_result_valid got %b exp 1", Result_valid); end
    checks++; if (Result_data !== 12'h321) begin errors++; $display("FAIL zero_result_data got %h exp 321", Result_data); end
    checks++; if (Result_timeout !== 1'b0) begin errors++; $display("FAIL zero_timeout got %b exp 0", Result_timeout); end
    tick();
    checks++; if (Result_valid !== 1'b0) begin errors++; $display("FAIL zero_result_pulse got %b exp 0", Result_valid); end
    checks++; if (Result_data !== 12'h321) begin errors++; $display("FAIL zero_result_hold got %h exp 321", Result_data); end
  endtask

  task automatic test_ones_key();
    int lat;
    logic got;
    start(32'hFFFF_FFFF);
    checks++; if (Hash_valid !== 1'b1) begin errors++; $display("FAIL ones_hash_valid got %b exp 1", Hash_valid); end
    // FFF^FFF^0FF, 7FF^7FF^3FF, 3FF^3FF^3FF
    checks++; if (Hash_add1 !== 12'h0FF) begin errors++; $display("FAIL ones_add1 got %h exp 0ff", Hash_add1); end
    checks++; if (Hash_add2 !== 11'h3FF) begin errors++; $display("FAIL ones_add2 got %h exp 3ff", Hash_add2); end
    checks++; if (Hash_add3 !== 10'h3FF) begin errors++; $display("FAIL ones_add3 got %h exp 3ff", Hash_add3); end
    tick();
    checks++; if (Hash_valid !== 1'b0) begin errors++; $display("FAIL ones_hash_valid_pulse got %b exp 0", Hash_valid); end
    strb(3'b111, 4'h4, 4'h5, 4'h6);
    tick();
    strb(3'b000, 4'h0, 4'h0, 4'h0);
    wait_result(5, lat, got);
    checks++; if (got !== 1'b1 || Result_data !== 12'h654) begin errors++; $display("FAIL ones_result got %b/%h exp 1/654", got, Result_data); end
    checks++; if (Hash_add1 !== 12'h0FF) begin errors++; $display("FAIL ones_add1_hold got %h exp 0ff", Hash_add1); end
  endtask

  task automatic test_staggered();
    int rv_cnt = 0;
    int rv_at = 0;
    logic [11:0] rd = 12'h0;
    logic rt = 1'b1;
    start(32'h1234_5678);
    checks++; if (Hash_add1 !== 12'h52F) begin errors++; $display("FAIL stag_add1 got %h exp 52f", Hash_add1); end
    checks++; if (Hash_add2 !== 11'h0BA) begin errors++; $display("FAIL stag_add2 got %h exp 0ba", Hash_add2); end
    checks++; if (Hash_add3 !== 10'h24E) begin errors++; $display("FAIL stag_add3 got %h exp 24e", Hash_add3); end
    for (int k = 1; k <= 10; k++) begin
      tick();
      strb({k == 6, k == 3, k == 1}, 4'hB, 4'hC, 4'hD);
      if (Result_valid === 1'b1) begin
        rv_cnt++;
        rv_at = k;
        rd = Result_data;
        rt = Result_timeout;
      end
      if (k <= 7) begin
        checks++; if (Key_ready !== 1'b0) begin errors++; $display("FAIL stag_key_ready cycle %0d got %b exp 0", k, Key_ready); end
      end
    end
    strb(3'b000, 4'h0, 4'h0, 4'h0);
    checks++; if (rv_cnt != 1) begin errors++; $display("FAIL stag_result_count got %0d exp 1", rv_cnt); end
    checks++; if (rv_at != 8) begin errors++; $display("FAIL stag_result_cycle got %0d exp 8", rv_at); end
    checks++; if (rd !== 12'hDCB || rt !== 1'b0) begin errors++; $display("FAIL stag_result got %h/%b exp dcb/0", rd, rt); end
  endtask

  task automatic test_timeout();
    int lat;
    logic got;
    start(32'hA5A5_0F0F);
    tick();
    strb(3'b001, 4'hA, 4'h0, 4'h0);
    tick();
    strb(3'b100, 4'h0, 4'h0, 4'h5);
    tick();
    strb(3'b000, 4'h0, 4'h0, 4'h0);
    wait_result(30, lat, got);
    checks++; if (got !== 1'b1) begin errors++; $display("FAIL to_result_seen got %b exp 1", got); end
    checks++; if (lat != 14) begin errors++; $display("FAIL to_latency got %0d exp 14", lat); end
    checks++; if (Result_timeout !== 1'b1) begin errors++; $display("FAIL to_flag got %b exp 1", Result_timeout); end
    checks++; if (Result_data !== 12'h50A) begin errors++; $display("FAIL to_data got %h exp 50a", Result_data); end
  endtask

  task automatic test_race();
    start(32'h0BAD_F00D);
    tick();
    strb(3'b101, 4'h6, 4'h0, 4'h8);
    tick();
    strb(3'b000, 4'h0, 4'h0, 4'h0);
    for (int k = 3; k <= 15; k++) tick();
    strb(3'b010, 4'h0, 4'hE, 4'h0);
    tick();
    strb(3'b000, 4'h0, 4'h0, 4'h0);
    checks++; if (Result_valid !== 1'b0) begin errors++; $display("FAIL race_early got %b exp 0", Result_valid); end
    tick();
    checks++; if (Result_valid !== 1'b1) begin errors++; $display("FAIL race_valid got %b exp 1", Result_valid); end
    checks++; if (Result_timeout !== 1'b0 || Result_data !== 12'h8E6) begin errors++; $display("FAIL race_result got %h/%b exp 8e6/0", Result_data, Result_timeout); end
  endtask

  task automatic test_reset_mid();
    int rv_cnt = 0;
    start(32'hDEAD_BEEF);
    tick();
    strb(3'b001, 4'hF, 4'h0, 4'h0);
    tick();
    strb(3'b000, 4'h0, 4'h0, 4'h0);
    Rst = 1'b1;
    tick();
    Rst = 1'b0;
    strb(3'b111, 4'h7, 4'h7, 4'h7);
    tick();
    strb(3'b000, 4'h0, 4'h0, 4'h0);
    for (int k = 0; k < 20; k++) begin
      if (Result_valid === 1'b1) rv_cnt++;
      tick();
    end
    checks++; if (rv_cnt != 0) begin errors++; $display("FAIL rmid_result_count got %0d exp 0", rv_cnt); end
    checks++; if (Key_ready !== 1'b1 || Hash_valid !== 1'b0) begin errors++; $display("FAIL rmid_ctrl got ready %b hv %b exp 1/0", Key_ready, Hash_valid); end
    checks++; if ({Hash_add1, Hash_add2, Hash_add3} !== 33'd0) begin errors++; $display("FAIL rmid_addr got %h/%h/%h exp 0", Hash_add1, Hash_add2, Hash_add3); end
    checks++; if (Result_data !== 12'h000 || Result_timeout !== 1'b0) begin errors++; $display("FAIL rmid_result got %h/%b exp 000/0", Result_data, Result_timeout); end
  endtask

  task automatic test_back_to_back();
    int lat;
    logic got;
    start(32'h0000_1000);
    tick();
    strb(3'b001, 4'h7, 4'h0, 4'h0);
    tick();
    strb(3'b111, 4'h9, 4'h2, 4'h3);
    tick();
    strb(3'b000, 4'h0, 4'h0, 4'h0);
    checks++; if (Key_ready !== 1'b0) begin errors++; $display("FAIL b2b_done_ready got %b exp 0", Key_ready); end
    Key_in = 32'h0000_0FFF;
    Key_valid = 1'b1;
    tick();
    checks++; if (Result_valid !== 1'b1 || Result_data !== 12'h329) begin errors++; $display("FAIL b2b_overwrite got %b/%h exp 1/329", Result_valid, Result_data); end
    checks++; if (Key_ready !== 1'b1 || Hash_valid !== 1'b0) begin errors++; $display("FAIL b2b_no_accept_in_done got ready %b hv %b exp 1/0", Key_ready, Hash_valid); end
    tick();
    Key_valid = 1'b0;
    checks++; if (Hash_valid !== 1'b1) begin errors++; $display("FAIL b2b_accept got %b exp 1", Hash_valid); end
    checks++; if (Hash_add1 !== 12'hFFF || Hash_add2 !== 11'h7FE || Hash_add3 !== 10'h3FC) begin errors++; $display("FAIL b2b_addr got %h/%h/%h exp fff/7fe/3fc", Hash_add1, Hash_add2, Hash_add3); end
    strb(3'b010, 4'h0, 4'hF, 4'h0);
    tick();
    strb(3'b101, 4'h1, 4'h0, 4'h1);
    tick();
    strb(3'b010, 4'h0, 4'h4, 4'h0);
    tick();
    strb(3'b000, 4'h0, 4'h0, 4'h0);
    wait_result(5, lat, got);
    checks++; if (got !== 1'b1 || lat != 1) begin errors++; $display("FAIL b2b_second_latency got %b/%0d exp 1/1", got, lat); end
    checks++; if (Result_data !== 12'h141 || Result_timeout !== 1'b0) begin errors++; $display("FAIL b2b_second_result got %h/%b exp 141/0", Result_data, Result_timeout); end
  endtask

  initial begin
    Rst = 1'b1;
    Key_valid = 1'b0;
    Key_in = 32'h0;
    strb(3'b000, 4'h0, 4'h0, 4'h0);
    test_reset();
    test_zero_key();
    test_ones_key();
    test_staggered();
    test_timeout();
    test_race();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
